// File: rtl/alu_operand_stage.sv
// Decode-to-execute register feeding the 32-bit ALU, with operand forwarding from the
// ALU's registered result and the writeback port. Define OPSTAGE_PERF_EN to add perf counters.
module alu_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5,
  parameter int IMM_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rs,
  input  logic [RADDR_W-1:0] in_rt,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [WIDTH-1:0]   in_rs_data,
  input  logic [WIDTH-1:0]   in_rt_data,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               in_use_imm,
  input  logic [2:0]         in_alu_ctrl,
  input  logic               in_reg_write,
  input  logic               flush,
  input  logic               ex_ready,
  input  logic [WIDTH-1:0]   alu_r,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [2:0]         out_alu_ctrl,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write
`ifdef OPSTAGE_PERF_EN
  ,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_flush,
  output logic [31:0]        perf_fwd_ex
`endif
);

  logic               valid_reg;
  logic [RADDR_W-1:0] rs_reg, rt_reg, rd_reg;
  logic [WIDTH-1:0]   rs_data_reg, rt_data_reg, imm_reg;
  logic               use_imm_reg;
  logic [2:0]         alu_ctrl_reg;
  logic               reg_write_reg;
  logic               ex_tag_v_reg;
  logic [RADDR_W-1:0] ex_tag_rd_reg;

  logic issue, capture;
  logic fwd_a_ex, fwd_b_ex, fwd_a_wb, fwd_b_wb;

  assign in_ready = !valid_reg || ex_ready;
  assign issue    = valid_reg && ex_ready;
  assign capture  = in_valid && in_ready && !flush;

  // The ex-tag only names a nonzero destination, so a match implies the source is nonzero.
  assign fwd_a_ex = ex_tag_v_reg && (ex_tag_rd_reg == rs_reg);
  assign fwd_b_ex = ex_tag_v_reg && (ex_tag_rd_reg == rt_reg) && !use_imm_reg;
  assign fwd_a_wb = wb_valid && (wb_rd == rs_reg);
  assign fwd_b_wb = wb_valid && (wb_rd == rt_reg);

  always_comb begin
    out_a = rs_data_reg;
    if (rs_reg == '0)  out_a = '0;
    else if (fwd_a_ex) out_a = alu_r;
    else if (fwd_a_wb) out_a = wb_data;
  end

  always_comb begin
    out_b = rt_data_reg;
    if (use_imm_reg)        out_b = imm_reg;
    else if (rt_reg == '0)  out_b = '0;
    else if (fwd_b_ex)      out_b = alu_r;
    else if (fwd_b_wb)      out_b = wb_data;
  end

  assign out_valid     = valid_reg;
  assign out_alu_ctrl  = alu_ctrl_reg;
  assign out_rd        = rd_reg;
  assign out_reg_write = reg_write_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg     <= 1'b0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      rd_reg        <= '0;
      rs_data_reg   <= '0;
      rt_data_reg   <= '0;
      imm_reg       <= '0;
      use_imm_reg   <= 1'b0;
      alu_ctrl_reg  <= 3'b000;
      reg_write_reg <= 1'b0;
      ex_tag_v_reg  <= 1'b0;
      ex_tag_rd_reg <= '0;
    end else begin
      // The ALU registers its result, so alu_r next cycle belongs to whatever issues now.
      ex_tag_v_reg  <= issue && reg_write_reg && (rd_reg != '0);
      ex_tag_rd_reg <= rd_reg;
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (capture) begin
        valid_reg     <= 1'b1;
        rs_reg        <= in_rs;
        rt_reg        <= in_rt;
        rd_reg        <= in_rd;
        rs_data_reg   <= in_rs_data;
        rt_data_reg   <= in_rt_data;
        imm_reg       <= {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        use_imm_reg   <= in_use_imm;
        alu_ctrl_reg  <= in_alu_ctrl;
        reg_write_reg <= in_reg_write;
      end else if (issue) begin
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef OPSTAGE_PERF_EN
  logic [31:0] perf_stall_reg, perf_flush_reg, perf_fwd_ex_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_reg  <= '0;
      perf_flush_reg  <= '0;
      perf_fwd_ex_reg <= '0;
    end else begin
      if (valid_reg && !ex_ready && perf_stall_reg != 32'hFFFF_FFFF)
        perf_stall_reg <= perf_stall_reg + 32'd1;
      if (flush && valid_reg && perf_flush_reg != 32'hFFFF_FFFF)
        perf_flush_reg <= perf_flush_reg + 32'd1;
      if (issue && (fwd_a_ex || fwd_b_ex) && perf_fwd_ex_reg != 32'hFFFF_FFFF)
        perf_fwd_ex_reg <= perf_fwd_ex_reg + 32'd1;
    end
  end

  assign perf_stall  = perf_stall_reg;
  assign perf_flush  = perf_flush_reg;
  assign perf_fwd_ex = perf_fwd_ex_reg;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed hazard scenarios with literal expectations, then
// randomized traffic checked each cycle against an issue-history reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_alu_ctrl;
  logic        in_reg_write, flush, ex_ready;
  logic [31:0] alu_r;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl), .in_reg_write(in_reg_write),
    .flush(flush), .ex_ready(ex_ready), .alu_r(alu_r),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
    .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        use_imm;
    logic [2:0]  ctrl;
    logic        rw;
  } instr_t;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     last_issue_cyc = -10;
  logic [4:0] last_rd = '0;
  logic   last_rw = 1'b0;
  bit     m_valid = 0;
  instr_t held, cur_in;
  logic [31:0] alu_next;

  function automatic instr_t mk(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rsd, logic [31:0] rtd, logic [15:0] imm,
                                logic ui, logic [2:0] ctrl, logic rw);
    instr_t i;
    i.rs = rs; i.rt = rt; i.rd = rd; i.rs_data = rsd; i.rt_data = rtd;
    i.imm = imm; i.use_imm = ui; i.ctrl = ctrl; i.rw = rw;
    return i;
  endfunction

  function automatic logic [31:0] sext(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] alu(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Source value: r0 is zero; the instruction issued last cycle wins; then writeback; else RF data.
  function automatic logic [31:0] src_value(logic [4:0] r, logic [31:0] rf);
    if (r == 5'd0) return '0;
    if (last_issue_cyc == cyc - 1 && last_rw && last_rd == r) return alu_r;
    if (wb_valid && wb_rd == r) return wb_data;
    return rf;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h want=0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic present(logic v, instr_t i);
    in_valid = v; in_rs = i.rs; in_rt = i.rt; in_rd = i.rd;
    in_rs_data = i.rs_data; in_rt_data = i.rt_data; in_imm = i.imm;
    in_use_imm = i.use_imm; in_alu_ctrl = i.ctrl; in_reg_write = i.rw;
    cur_in = i;
  endtask

  // Called at a negedge with inputs driven: compare, advance the model, pass one clock edge.
  task automatic cycle();
    logic [31:0] ea, eb;
    bit rdy, issue, cap;
    #1;
    rdy = !m_valid || ex_ready;
    ea  = src_value(held.rs, held.rs_data);
    eb  = held.use_imm ? sext(held.imm) : src_value(held.rt, held.rt_data);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_a", out_a, ea);
      chk("out_b", out_b, eb);
      chk("out_alu_ctrl", 32'(out_alu_ctrl), 32'(held.ctrl));
      chk("out_rd", 32'(out_rd), 32'(held.rd));
      chk("out_reg_write", 32'(out_reg_write), 32'(held.rw));
    end
    issue    = m_valid && ex_ready;
    cap      = in_valid && rdy && !flush;
    alu_next = alu(ea, eb, held.ctrl);
    if (issue) begin
      last_issue_cyc = cyc; last_rd = held.rd; last_rw = held.rw;
    end
    if (flush)      m_valid = 0;
    else if (cap) begin held = cur_in; m_valid = 1; end
    else if (issue) m_valid = 0;
    @(posedge clk);
    #1;
    alu_r = alu_next;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_alu_ctrl", 32'(out_alu_ctrl), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_reg_write", 32'(out_reg_write), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_valid = 0;
    held = mk('0, '0, '0, '0, '0, '0, 1'b0, 3'd0, 1'b0);
    last_issue_cyc = -10;
    alu_r = '0;
    cyc++;
  endtask

  initial begin
    instr_t i;
    present(1'b0, mk('0, '0, '0, '0, '0, '0, 1'b0, 3'd0, 1'b0));
    flush = 1'b0; ex_ready = 1'b1; alu_r = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    held = cur_in;
    do_reset();

    // Back-to-back ADD r3=r1+r2 then SUB r4=r3-r1, r1=5, r2=7.
    present(1'b1, mk(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0, 1'b0, 3'd0, 1'b1));
    cycle();
    present(1'b1, mk(5'd3, 5'd1, 5'd4, 32'hDEAD, 32'd5, 16'h0, 1'b0, 3'd1, 1'b1));
    #1;
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    cycle();
    // Immediate XOR, rt=r4 matches the SUB just issued but must be ignored.
    present(1'b1, mk(5'd2, 5'd4, 5'd5, 32'd7, 32'h1234, 16'h8001, 1'b1, 3'd2, 1'b1));
    #1;
    chk("sub_a_fwd_ex", out_a, 32'd12);
    chk("sub_b", out_b, 32'd5);
    cycle();
    chk("sub_alu_result", alu_r, 32'd7);

    // Stall three cycles with a new instruction waiting (it reads XOR's r5).
    present(1'b1, mk(5'd5, 5'd0, 5'd9, 32'd111, 32'd0, 16'h0, 1'b0, 3'd0, 1'b1));
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("xor_a", out_a, 32'd7);
      chk("xor_b_imm", out_b, 32'hFFFF8001);
      cycle();
    end
    ex_ready = 1'b1;
    cycle();
    #1;
    chk("post_stall_valid", 32'(out_valid), 32'd1);
    chk("post_stall_rd", 32'(out_rd), 32'd9);
    chk("post_stall_a_fwd_ex", out_a, 32'hFFFF8006);

    // Issue r9 writer, capture its reader, then flush it while a new instruction arrives.
    present(1'b1, mk(5'd9, 5'd9, 5'd10, 32'd3, 32'd4, 16'h0, 1'b0, 3'd1, 1'b1));
    cycle();
    present(1'b1, mk(5'd1, 5'd1, 5'd12, 32'd1, 32'd1, 16'h0, 1'b0, 3'd0, 1'b1));
    flush = 1'b1; ex_ready = 1'b0;
    #1;
    chk("flush_cycle_a_fwd_ex", out_a, 32'hFFFF8006);
    chk("flush_cycle_b_fwd_ex", out_b, 32'hFFFF8006);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flushed_valid", 32'(out_valid), 32'd0);
    chk("flushed_in_ready", 32'(in_ready), 32'd1);
    cycle();

    // Writeback forwarding.
    ex_ready = 1'b1;
    present(1'b1, mk(5'd6, 5'd0, 5'd11, 32'd1, 32'd0, 16'h0, 1'b0, 3'd0, 1'b1));
    cycle();
    in_valid = 1'b0; ex_ready = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'd99;
    #1;
    chk("wb_fwd_a", out_a, 32'd99);
    cycle();
    ex_ready = 1'b1; wb_rd = 5'd0;
    present(1'b1, mk(5'd0, 5'd3, 5'd13, 32'h77, 32'd2, 16'h0, 1'b0, 3'd0, 1'b1));
    cycle();
    in_valid = 1'b0; ex_ready = 1'b0;
    #1;
    chk("wb_r0_a", out_a, 32'd0);
    cycle();

    // Asynchronous reset while an instruction is stalled.
    ex_ready = 1'b1; wb_valid = 1'b0;
    present(1'b1, mk(5'd7, 5'd0, 5'd14, 32'h55, 32'd0, 16'h0, 1'b0, 3'd0, 1'b1));
    cycle();
    ex_ready = 1'b0;
    #1;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    chk("pre_reset_a", out_a, 32'h55);
    do_reset();

    // Randomized traffic with a small register range to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      i = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom, $urandom, 16'($urandom), 1'($urandom_range(0, 2) == 0),
             3'($urandom_range(0, 4)), 1'($urandom_range(0, 3) != 0));
      present(1'($urandom_range(0, 3) != 0), i);
      flush    = 1'($urandom_range(0, 9) == 0);
      ex_ready = 1'($urandom_range(0, 3) != 0);
      wb_valid = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      if (n % 700 == 350) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the 32-bit ALU and drives its A, B and ALUControl inputs.
- Captures decoded instructions with a valid/ready handshake and supports stall and flush.
- Resolves RAW hazards by forwarding the ALU's registered result R, or the writeback value, onto the operand outputs.
- Tracks which instruction the ALU's registered R belongs to, so no external forwarding unit is needed.

Parameters:
- WIDTH, 32, datapath width of operands and results.
- RADDR_W, 5, register-address width; register 0 is hardwired zero.
- IMM_W, 16, immediate width; sign-extended to WIDTH at capture.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rs, in_rt, in_rd  in  RADDR_W each  source and destination register numbers.
- in_rs_data, in_rt_data  in  WIDTH each  register-file read data.
- in_imm  in  IMM_W  raw immediate.
- in_use_imm  in  1  B operand comes from the immediate, not rt.
- in_alu_ctrl  in  3  opcode: 000 ADD, 001 SUB, 010 XOR, others give result 0.
- in_reg_write  in  1  instruction writes in_rd.
- flush  in  1  kill the held instruction.
- ex_ready  in  1  downstream EX/MEM accepts this cycle.
- alu_r  in  WIDTH  ALU registered result.
- wb_valid  in  1  writeback port active.
- wb_rd  in  RADDR_W  writeback destination.
- wb_data  in  WIDTH  writeback data.
- out_valid  out  1  held instruction valid.
- out_a, out_b  out  WIDTH  forwarded operands to ALU A and B.
- out_alu_ctrl  out  3  to ALUControl.
- out_rd  out  RADDR_W  destination of the held instruction.
- out_reg_write  out  1  write enable of the held instruction.

Behaviour:
- Reset (async): out_valid=0, all held fields 0, ex-tag valid=0, counters 0. Outputs are therefore out_a=0, out_b=0, out_alu_ctrl=000, out_rd=0, out_reg_write=0.
- in_ready = !out_valid || ex_ready (combinational). Issue fires when out_valid && ex_ready.
- Capture: on an edge with in_valid && in_ready && !flush, latch all in_* fields and set out_valid=1.
  - The immediate is sign-extended to WIDTH at capture.
  - If in_use_imm=1, the held B source is the immediate and rt forwarding is disabled for that instruction.
- Issue without a new capture: out_valid <= 0.
- Stall (out_valid && !ex_ready): all held fields unchanged.
- Flush has priority over capture and hold. The next edge sets out_valid=0 and the incoming instruction is dropped. Flush does not touch the ex-tag.
- Ex-tag: on every edge, set ex_tag_v <= (issue fired && out_reg_write && out_rd!=0), with ex_tag_rd <= out_rd.
  - The ALU registers its result, so alu_r in cycle N+1 is the result of the instruction issued in cycle N.
- Operand A source is selected combinationally, highest priority first:
  1. held rs==0 gives 0.
  2. ex_tag_v && ex_tag_rd==rs gives alu_r.
  3. wb_valid && wb_rd==rs gives wb_data.
  4. Otherwise the held rs_data.
- Operand B uses the same priority on rt, unless use_imm=1, in which case B is the immediate.
- Forwarding is re-evaluated every cycle while stalled.
  - A forward from alu_r is valid only in the cycle immediately after its issue.
  - Because the ALU recomputes while stalled, no forward from alu_r occurs after a stall cycle. The operand must then come from WB.
- Simultaneous capture and issue in the same cycle: the new instruction replaces the old, out_valid stays 1, and ex-tag takes the old instruction.
- Reset asserted mid-stall discards the held instruction and the ex-tag immediately.

Optional Feature:
- Macro: OPSTAGE_PERF_EN.
- Defined: adds three 32-bit saturating counters, reset to 0, exposed as outputs perf_stall, perf_flush, perf_fwd_ex.
  - perf_stall increments on each cycle with out_valid && !ex_ready.
  - perf_flush increments on each cycle with flush && out_valid.
  - perf_fwd_ex increments on each issue where either operand came from alu_r.
  - Counters hold at 32'hFFFFFFFF.
- Undefined: no counters and no extra ports. Behaviour is otherwise identical.

Test Plan:
- Reset mid-operation: assert reset while out_valid=1 -> out_valid=0 and out_a=0 with no clock edge needed; in_ready=1.
- Back-to-back ADD r3=r1+r2, then SUB r4=r3-r1, with r1=5, r2=7, ex_ready=1 -> second issue sees out_a=alu_r=12 and out_b=5; ALU then produces 7.
- Immediate XOR with in_imm=16'h8001 and use_imm=1, rs=r2=7 -> out_b=32'hFFFF8001; rt forwarding ignored even when rt matches ex_tag_rd.
- Stall: ex_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, held fields stable; the instruction issues in the cycle ex_ready returns, and the next one is captured on that same edge.
- Flush and capture on the same edge with in_valid=1 -> out_valid=0 and the incoming instruction is dropped; ex-tag from the prior issue is still used on the next cycle.
- Writeback forwarding: wb_valid=1, wb_rd=r6, wb_data=99, with held rs=r6 and no ex match -> out_a=99. With wb_rd=0, rs=0 -> out_a=0.
